vector_sequencer_ctrl: RTL and testbench
========================================

Name: vector_sequencer_ctrl

Overview:
Multi-cycle, parametrised successor to the single-cycle opcode decoder of the vector encryption CPU. Accepts one 4-bit opcode per valid/ready handshake, owns the loop counter used by SETC/DEC/BNZ, and sequences matrix ops over several lane beats. Emits registered per-beat control strobes (reg_write, mem_write, res_src, alu_control, branch) to the datapath. Sits between instruction fetch and the vector ALU/register file/memory write-back.

Parameters:
OPW, 4, opcode width
ALUW, 4, alu_control width
LANES, 16, byte lanes per matrix op (4x4 state)
LANES_PER_BEAT, 4, lanes processed per cycle; LANES must be a multiple; BEATS = LANES/LANES_PER_BEAT
CNTW, 4, loop counter width
LOOP_INIT, 10, value loaded by SETC

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  opcode present
instr_ready  out  1  opcode accepted when valid&ready
opcode  in  OPW  operation code
ex_stall  in  1  datapath back-pressure; holds current beat
op_active  out  1  control outputs valid this cycle
alu_control  out  ALUW  ALU operation
res_src  out  2  write-back mux select (0 ALU, 1 memory)
reg_write  out  1  register write strobe
mem_write  out  1  memory write strobe
branch  out  1  BNZ taken
beat_idx  out  max(1,clog2(BEATS))  current beat; lane base = beat_idx*LANES_PER_BEAT
last_beat  out  1  final beat of current op
loop_count  out  CNTW  loop counter value
count_zero  out  1  loop_count==0
halted  out  1  end-of-program reached

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 except instr_ready=0 during reset and 1 on first cycle after release; loop_count=0; count_zero=1.
- States: IDLE, EXEC, HALT.
- IDLE: instr_ready=1. On valid&ready, latch opcode and go to EXEC with beat_idx=0. Opcode 0000 or 1101-1111 goes to HALT instead.
- EXEC: op_active=1; alu_control=opcode. Single-beat ops: 0001 SETC, 0010 DEC, 0011 BNZ. Multi-beat ops: 0100-1100, BEATS cycles.
- Per-opcode flags:
  - 0001-0100: reg_write=1, res_src=0.
  - 0101: reg_write=1, res_src=1.
  - 0110: mem_write=1, res_src=1.
  - 0111-1100: no writes; res_src=1 for 0111-1000, 0 otherwise.
- Strobes gated: reg_write/mem_write = flag & !ex_stall.
- ex_stall=1: beat_idx, state and all outputs hold; no strobe. Beat advances only on !ex_stall.
- Last beat (last_beat=1): if !ex_stall, instr_ready=1. A new opcode accepted that cycle enters EXEC beat 0 next cycle (back-to-back). Otherwise go to IDLE.
- Loop counter, updated at the edge ending the unstalled EXEC cycle:
  - SETC loads LOOP_INIT.
  - DEC: loop_count-1, saturating at 0.
  - BNZ: branch=1 in its EXEC cycle iff loop_count!=0 (value after any prior DEC).
  - branch is 0 for all other opcodes.
- HALT: instr_ready=0, op_active=0, halted=1; exit only by reset.
- Reset mid-op: aborts immediately; no residual strobes after release.
- Latency: accept at edge N, first control beat in cycle N+1. Single-beat op = 1 cycle; matrix op = BEATS cycles plus stalls.

Decomposition:
- Package vec_ctrl_pkg: opcode enum (SETC, DEC, BNZ, MATSET, MATXOR, SBOXROT, XORFL, XORKEY, MSHL, MSUB, MSHR, MMIX, END); res_src constants; ctrl_flags_t struct {reg_write, mem_write, res_src, multi_beat}; decode function opcode->ctrl_flags_t.
- Sub-module loop_counter (load/dec-saturate/zero flag, CNTW-wide) is natural; beat counter stays inline.

Test Plan:
- Reset then SETC, BNZ → BNZ cycle branch=1, loop_count=10, reg_write=1 on SETC cycle.
- SETC followed by 10 DEC+BNZ pairs back-to-back → branch=1 on first 9 BNZ, 0 on 10th; an 11th DEC keeps loop_count=0 (saturate).
- MATXOR (0101) default params → 4 cycles op_active, beat_idx 0,1,2,3, reg_write each beat, res_src=1, last_beat only on beat 3.
- 0110 with ex_stall high in beat 1 for 3 cycles → beat_idx holds 1, mem_write=0 during stall; 7 EXEC cycles total; 4 mem_write pulses.
- Back-to-back MSUB then MMIX with instr_valid held → MMIX beat 0 in cycle immediately after MSUB beat 3; no IDLE gap.
- Opcode 1111 → halted=1, instr_ready=0 forever; rst_n pulsed low mid-MATSET beat 2 → all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared opcode map, write-back select codes and per-opcode control flags
// for the vector sequencer controller.
package vec_ctrl_pkg;

  localparam int OP_BITS = 4;

  typedef enum logic [OP_BITS-1:0] {
    END     = 4'd0,
    SETC    = 4'd1,
    DEC     = 4'd2,
    BNZ     = 4'd3,
    MATSET  = 4'd4,
    MATXOR  = 4'd5,
    SBOXROT = 4'd6,
    XORFL   = 4'd7,
    XORKEY  = 4'd8,
    MSHL    = 4'd9,
    MSUB    = 4'd10,
    MSHR    = 4'd11,
    MMIX    = 4'd12
  } opcode_e;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] res_src;
    logic       multi_beat;
  } ctrl_flags_t;

  // Anything outside SETC..MMIX (END and the reserved tail) stops the program.
  function automatic logic isExecOp(input logic [OP_BITS-1:0] op);
    return (op >= 4'(SETC)) && (op <= 4'(MMIX));
  endfunction

  function automatic ctrl_flags_t decodeOp(input logic [OP_BITS-1:0] op);
    ctrl_flags_t flags;
    // NOTE: every field gets a default before the case so no path can infer a latch.
    flags = '0;
    flags.res_src = RES_ALU;
    case (op)
      SETC, DEC, BNZ: flags.reg_write = 1'b1;
      MATSET: begin
        flags.reg_write  = 1'b1;
        flags.multi_beat = 1'b1;
      end
      MATXOR: begin
        flags.reg_write  = 1'b1;
        flags.res_src    = RES_MEM;
        flags.multi_beat = 1'b1;
      end
      SBOXROT: begin
        flags.mem_write  = 1'b1;
        flags.res_src    = RES_MEM;
        flags.multi_beat = 1'b1;
      end
      XORFL, XORKEY: begin
        flags.res_src    = RES_MEM;
        flags.multi_beat = 1'b1;
      end
      MSHL, MSUB, MSHR, MMIX: flags.multi_beat = 1'b1;
      default: ;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/vector_sequencer_ctrl_loop_counter.sv
// Program loop counter: loads a fixed start value, decrements with
// saturation at zero, and flags zero for the branch decision.
module loop_counter #(
  parameter int CNTW      = 4,
  parameter int LOOP_INIT = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            dec,
  output logic [CNTW-1:0] count,
  output logic            zero
);

  logic [CNTW-1:0] countReg;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= CNTW'(LOOP_INIT);
    end else if (dec && (countReg != '0)) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign count = countReg;
  assign zero  = (countReg == '0);

endmodule

// File: rtl/vector_sequencer_ctrl.sv
// Multi-cycle opcode sequencer: accepts one opcode per handshake and drives
// per-beat datapath strobes, stretching matrix ops over BEATS lane beats.
module vector_sequencer_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int OPW            = 4,
  parameter int ALUW           = 4,
  parameter int LANES          = 16,
  parameter int LANES_PER_BEAT = 4,
  parameter int CNTW           = 4,
  parameter int LOOP_INIT      = 10,
  localparam int BEATS         = LANES / LANES_PER_BEAT,
  localparam int BW            = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic            ex_stall,
  output logic            op_active,
  output logic [ALUW-1:0] alu_control,
  output logic [1:0]      res_src,
  output logic            reg_write,
  output logic            mem_write,
  output logic            branch,
  output logic [BW-1:0]   beat_idx,
  output logic            last_beat,
  output logic [CNTW-1:0] loop_count,
  output logic            count_zero,
  output logic            halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [1:0]     state;
  logic [OPW-1:0] opReg;
  logic [BW-1:0]  beatReg;

  ctrl_flags_t flags;
  logic        inExec;
  logic        isLastBeat;
  logic        advance;
  logic        acceptSlot;
  logic        accept;
  logic        opcodeLegal;

  assign flags       = decodeOp(4'(opReg));
  assign inExec      = (state == S_EXEC);
  assign isLastBeat  = inExec && (flags.multi_beat ? (beatReg == LAST_BEAT) : (beatReg == '0));
  assign advance     = inExec && !ex_stall;
  // rst_n keeps ready low while reset is held even though state already reads IDLE.
  assign acceptSlot  = rst_n && ((state == S_IDLE) || (isLastBeat && !ex_stall));
  assign accept      = instr_valid && acceptSlot;
  assign opcodeLegal = ((opcode >> 4) == '0) && isExecOp(4'(opcode));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      opReg   <= '0;
      beatReg <= '0;
    end else if (accept) begin
      state   <= opcodeLegal ? S_EXEC : S_HALT;
      opReg   <= opcode;
      beatReg <= '0;
    end else if (advance) begin
      if (isLastBeat) begin
        state   <= S_IDLE;
        beatReg <= '0;
      end else begin
        beatReg <= beatReg + 1'b1;
      end
    end
  end

  loop_counter #(
    .CNTW      (CNTW),
    .LOOP_INIT (LOOP_INIT)
  ) u_loopCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (advance && (4'(opReg) == 4'(SETC))),
    .dec   (advance && (4'(opReg) == 4'(DEC))),
    .count (loop_count),
    .zero  (count_zero)
  );

  assign instr_ready = acceptSlot;
  assign op_active   = inExec;
  assign alu_control = inExec ? ALUW'(opReg) : '0;
  assign res_src     = inExec ? flags.res_src : RES_ALU;
  assign reg_write   = advance && flags.reg_write;
  assign mem_write   = advance && flags.mem_write;
  assign branch      = inExec && (4'(opReg) == 4'(BNZ)) && !count_zero;
  assign beat_idx    = beatReg;
  assign last_beat   = isLastBeat;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_vector_sequencer_ctrl.sv
// Directed bench for vector_sequencer_ctrl: handshake, loop counter,
// multi-beat sequencing, stall hold, back-to-back issue, halt and reset abort.
module tb_vector_sequencer_ctrl;

  localparam logic [3:0] OPC_SETC   = 4'd1;
  localparam logic [3:0] OPC_DEC    = 4'd2;
  localparam logic [3:0] OPC_BNZ    = 4'd3;
  localparam logic [3:0] OPC_MATSET = 4'd4;
  localparam logic [3:0] OPC_MATXOR = 4'd5;
  localparam logic [3:0] OPC_SBOX   = 4'd6;
  localparam logic [3:0] OPC_MSUB   = 4'd10;
  localparam logic [3:0] OPC_MMIX   = 4'd12;
  localparam logic [3:0] OPC_BAD    = 4'd15;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic       ex_stall;
  logic       op_active;
  logic [3:0] alu_control;
  logic [1:0] res_src;
  logic       reg_write;
  logic       mem_write;
  logic       branch;
  logic [1:0] beat_idx;
  logic       last_beat;
  logic [3:0] loop_count;
  logic       count_zero;
  logic       halted;

  int total = 0;
  int bad   = 0;

  vector_sequencer_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .ex_stall    (ex_stall),
    .op_active   (op_active),
    .alu_control (alu_control),
    .res_src     (res_src),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .branch      (branch),
    .beat_idx    (beat_idx),
    .last_beat   (last_beat),
    .loop_count  (loop_count),
    .count_zero  (count_zero),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int execCycles;
    int memPulses;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 4'd0;
    ex_stall    = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst ready", 32'(instr_ready), 0);
    check("rst active", 32'(op_active), 0);
    check("rst count", 32'(loop_count), 0);
    check("rst zero", 32'(count_zero), 1);
    check("rst halted", 32'(halted), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst ready", 32'(instr_ready), 1);

    // SETC then BNZ back-to-back.
    instr_valid = 1'b1;
    opcode      = OPC_SETC;
    cyc();
    opcode = OPC_BNZ;
    @(negedge clk);
    check("setc active", 32'(op_active), 1);
    check("setc reg_write", 32'(reg_write), 1);
    check("setc alu", 32'(alu_control), 1);
    check("setc last", 32'(last_beat), 1);
    check("setc count before", 32'(loop_count), 0);
    cyc();
    instr_valid = 1'b0;
    @(negedge clk);
    check("bnz branch", 32'(branch), 1);
    check("bnz count", 32'(loop_count), 10);
    check("bnz alu", 32'(alu_control), 3);
    cyc();
    @(negedge clk);
    check("idle after bnz", 32'(op_active), 0);

    // SETC followed by ten DEC/BNZ pairs, then a saturating eleventh DEC.
    instr_valid = 1'b1;
    opcode      = OPC_SETC;
    cyc();
    for (int i = 0; i < 10; i++) begin
      opcode = OPC_DEC;
      cyc();
      opcode = OPC_BNZ;
      cyc();
      @(negedge clk);
      check($sformatf("loop%0d branch", i), 32'(branch), (i < 9) ? 1 : 0);
      check($sformatf("loop%0d count", i), 32'(loop_count), 9 - i);
    end
    opcode = OPC_DEC;
    cyc();
    instr_valid = 1'b0;
    @(negedge clk);
    check("dec11 reg_write", 32'(reg_write), 1);
    cyc();
    @(negedge clk);
    check("dec11 saturate", 32'(loop_count), 0);
    check("dec11 zero", 32'(count_zero), 1);

    // MATXOR over four beats.
    instr_valid = 1'b1;
    opcode      = OPC_MATXOR;
    cyc();
    instr_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check($sformatf("mx b%0d active", b), 32'(op_active), 1);
      check($sformatf("mx b%0d beat", b), 32'(beat_idx), b);
      check($sformatf("mx b%0d reg_write", b), 32'(reg_write), 1);
      check($sformatf("mx b%0d res_src", b), 32'(res_src), 1);
      check($sformatf("mx b%0d last", b), 32'(last_beat), (b == 3) ? 1 : 0);
      check($sformatf("mx b%0d ready", b), 32'(instr_ready), (b == 3) ? 1 : 0);
      cyc();
    end
    @(negedge clk);
    check("mx done", 32'(op_active), 0);

    // SBOXROT with a three-cycle stall in beat 1.
    instr_valid = 1'b1;
    opcode      = OPC_SBOX;
    cyc();
    instr_valid = 1'b0;
    execCycles  = 0;
    memPulses   = 0;
    for (int k = 0; k < 10; k++) begin
      ex_stall = (k >= 1 && k <= 3);
      @(negedge clk);
      if (op_active) execCycles++;
      if (mem_write) memPulses++;
      if (k >= 1 && k <= 4) check($sformatf("stall k%0d beat", k), 32'(beat_idx), 1);
      if (k >= 1 && k <= 3) check($sformatf("stall k%0d mem_write", k), 32'(mem_write), 0);
      if (k == 4) check("stall release mem_write", 32'(mem_write), 1);
      cyc();
    end
    ex_stall = 1'b0;
    check("stall exec cycles", execCycles, 7);
    check("stall mem pulses", memPulses, 4);

    // MSUB then MMIX with valid held: no idle gap.
    instr_valid = 1'b1;
    opcode      = OPC_MSUB;
    cyc();
    opcode = OPC_MMIX;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check($sformatf("msub b%0d alu", b), 32'(alu_control), 10);
      check($sformatf("msub b%0d beat", b), 32'(beat_idx), b);
      check($sformatf("msub b%0d writes", b), 32'({reg_write, mem_write}), 0);
      cyc();
    end
    instr_valid = 1'b0;
    @(negedge clk);
    check("mmix follow active", 32'(op_active), 1);
    check("mmix follow alu", 32'(alu_control), 12);
    check("mmix follow beat", 32'(beat_idx), 0);
    repeat (4) cyc();
    @(negedge clk);
    check("mmix done", 32'(op_active), 0);

    // SETC then MATSET, reset asserted asynchronously in MATSET beat 2.
    instr_valid = 1'b1;
    opcode      = OPC_SETC;
    cyc();
    opcode = OPC_MATSET;
    cyc();
    instr_valid = 1'b0;
    repeat (2) cyc();
    check("matset beat2", 32'(beat_idx), 2);
    check("matset count", 32'(loop_count), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort active", 32'(op_active), 0);
    check("abort beat", 32'(beat_idx), 0);
    check("abort reg_write", 32'(reg_write), 0);
    check("abort alu", 32'(alu_control), 0);
    check("abort ready", 32'(instr_ready), 0);
    check("abort count", 32'(loop_count), 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort idle ready", 32'(instr_ready), 1);
    check("abort idle active", 32'(op_active), 0);
    check("abort idle reg_write", 32'(reg_write), 0);

    // Reserved opcode halts until reset.
    instr_valid = 1'b1;
    opcode      = OPC_BAD;
    cyc();
    opcode = OPC_SETC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("halt k%0d halted", k), 32'(halted), 1);
      check($sformatf("halt k%0d ready", k), 32'(instr_ready), 0);
      check($sformatf("halt k%0d active", k), 32'(op_active), 0);
      check($sformatf("halt k%0d count", k), 32'(loop_count), 0);
      cyc();
    end
    instr_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
